// File: rtl/frc_axil_pkg.sv
// frc_axil_pkg: shared response codes, FSM state types and address decode for frc_axil_regbank
package frc_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   // word index of a byte address; low (sub-word) bits are dropped
   function automatic logic [31:0] addr_to_idx(input logic [63:0] addr, input int unsigned lsb);
      return 32'(addr >> lsb);
   endfunction

endpackage

// File: rtl/frc_axil_regbank_wstrb_merge.sv
// frc_axil_regbank_wstrb_merge: byte-wise merge of old register data with write data under WSTRB
module frc_axil_regbank_wstrb_merge #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_data,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   merged
);

   for (genvar b = 0; b < DATA_W/8; b++) begin : g_byte
      assign merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_data[8*b +: 8];
   end

endmodule

// File: rtl/frc_axil_regbank.sv
// frc_axil_regbank: AXI4-Lite register bank with byte strobes, read-only mask, SLVERR and write pulses; FRC_SHADOW_EN adds shadow registers and commit_in
module frc_axil_regbank
   import frc_axil_pkg::*;
#(
   parameter int                       DATA_W    = 32,
   parameter int                       NUM_REGS  = 8,
   parameter int                       ADDR_W    = 12,
   parameter logic [NUM_REGS-1:0]      RO_MASK   = '0,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                       S_AXI_ACLK,
   input  logic                       S_AXI_ARESET,
   input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                 S_AXI_AWPROT,
   input  logic                       S_AXI_AWVALID,
   output logic                       S_AXI_AWREADY,
   input  logic [DATA_W-1:0]          S_AXI_WDATA,
   input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
   input  logic                       S_AXI_WVALID,
   output logic                       S_AXI_WREADY,
   output logic [1:0]                 S_AXI_BRESP,
   output logic                       S_AXI_BVALID,
   input  logic                       S_AXI_BREADY,
   input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                 S_AXI_ARPROT,
   input  logic                       S_AXI_ARVALID,
   output logic                       S_AXI_ARREADY,
   output logic [DATA_W-1:0]          S_AXI_RDATA,
   output logic [1:0]                 S_AXI_RRESP,
   output logic                       S_AXI_RVALID,
   input  logic                       S_AXI_RREADY,
   output logic [NUM_REGS*DATA_W-1:0] ctrl_out,
   input  logic [NUM_REGS*DATA_W-1:0] status_in,
`ifdef FRC_SHADOW_EN
   input  logic                       commit_in,
`endif
   output logic [NUM_REGS-1:0]        wr_pulse
);

   localparam int SW       = DATA_W/8;
   localparam int ADDR_LSB = $clog2(SW);
   localparam int IW       = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

   logic [DATA_W-1:0] regs [NUM_REGS];
   wstate_t           wstate;
   rstate_t           rstate;
   logic              aw_held, w_held;
   logic [ADDR_W-1:0] awaddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [SW-1:0]     wstrb_q;
   logic [1:0]        bresp_q, rresp_q;
   logic [DATA_W-1:0] rdata_q;
   logic [NUM_REGS-1:0] pulse_q;

   logic              aw_hs, w_hs, commit, w_in, w_en, r_in;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata_c, old_w, merged, rd_src, rval;
   logic [SW-1:0]     wstrb_c;
   logic [31:0]       widx_full, ridx_full;
   logic [IW-1:0]     widx, ridx;
   logic              unused;

   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   assign S_AXI_AWREADY = wstate == W_IDLE && !aw_held;
   assign S_AXI_WREADY  = wstate == W_IDLE && !w_held;
   assign S_AXI_BVALID  = wstate == W_RESP;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = rstate == R_IDLE;
   assign S_AXI_RVALID  = rstate == R_DATA;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign wr_pulse      = pulse_q;

   // a half already latched stands in for its live channel, so AW and W may arrive in any order
   assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
   assign commit    = wstate == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
   assign waddr     = aw_held ? awaddr_q : S_AXI_AWADDR;
   assign wdata_c   = w_held ? wdata_q : S_AXI_WDATA;
   assign wstrb_c   = w_held ? wstrb_q : S_AXI_WSTRB;
   assign widx_full = addr_to_idx(64'(waddr), ADDR_LSB);
   assign w_in      = widx_full < 32'(NUM_REGS);
   assign widx      = w_in ? IW'(widx_full) : '0;
   assign w_en      = commit && w_in && !RO_MASK[widx];

   assign ridx_full = addr_to_idx(64'(S_AXI_ARADDR), ADDR_LSB);
   assign r_in      = ridx_full < 32'(NUM_REGS);
   assign ridx      = r_in ? IW'(ridx_full) : '0;
   assign rval      = !r_in ? '0 : RO_MASK[ridx] ? status_in[ridx*DATA_W +: DATA_W] : rd_src;

   frc_axil_regbank_wstrb_merge #(.DATA_W(DATA_W)) u_merge (
      .old_data (old_w),
      .wdata    (wdata_c),
      .wstrb    (wstrb_c),
      .merged   (merged)
   );

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign ctrl_out[i*DATA_W +: DATA_W] = regs[i];
   end

`ifdef FRC_SHADOW_EN
   logic [DATA_W-1:0] shadow [NUM_REGS];

   assign old_w  = shadow[widx];
   assign rd_src = shadow[ridx];

   // writes land in the shadow; commit_in publishes every shadow at once, folding in a same-cycle write
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
      if (S_AXI_ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            regs[i]   <= RESET_VAL[i*DATA_W +: DATA_W];
         end
      end else begin
         if (w_en)
            shadow[widx] <= merged;
         if (commit_in)
            for (int i = 0; i < NUM_REGS; i++)
               regs[i] <= (w_en && widx == IW'(i)) ? merged : shadow[i];
      end
`else
   assign old_w  = regs[widx];
   assign rd_src = regs[ridx];

   // writes go straight to the live registers
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
      if (S_AXI_ARESET) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end else if (w_en)
         regs[widx] <= merged;
`endif

   // write channel: latch AW/W halves, commit once both are present, hold B until BREADY
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
      if (S_AXI_ARESET) begin
         wstate   <= W_IDLE;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
         pulse_q  <= '0;
      end else begin
         pulse_q <= '0;
         if (wstate == W_IDLE) begin
            if (commit) begin
               aw_held <= 1'b0;
               w_held  <= 1'b0;
               wstate  <= W_RESP;
               bresp_q <= w_in ? RESP_OKAY : RESP_SLVERR;
               if (w_in)
                  pulse_q <= NUM_REGS'(1) << widx;
            end else begin
               if (aw_hs) begin
                  aw_held  <= 1'b1;
                  awaddr_q <= S_AXI_AWADDR;
               end
               if (w_hs) begin
                  w_held  <= 1'b1;
                  wdata_q <= S_AXI_WDATA;
                  wstrb_q <= S_AXI_WSTRB;
               end
            end
         end else if (S_AXI_BREADY)
            wstate <= W_IDLE;
      end

   // read channel: sample on the AR handshake, hold R until RREADY
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
      if (S_AXI_ARESET) begin
         rstate  <= R_IDLE;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (rstate == R_IDLE) begin
         if (S_AXI_ARVALID) begin
            rstate  <= R_DATA;
            rdata_q <= rval;
            rresp_q <= r_in ? RESP_OKAY : RESP_SLVERR;
         end
      end else if (S_AXI_RREADY)
         rstate <= R_IDLE;

endmodule

// File: tb/tb_frc_axil_regbank.sv
// tb_frc_axil_regbank: directed self-checking bench for frc_axil_regbank (default build or FRC_SHADOW_EN)
module tb_frc_axil_regbank;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [11:0]  awaddr = '0, araddr = '0;
   logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [255:0] ctrl_out;
   logic [255:0] status_in = {32'hDEADBEEF, {7{32'h5A5A5A5A}}};
   logic [7:0]   wr_pulse;
`ifdef FRC_SHADOW_EN
   logic         commit_in = 1'b0;
`endif
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   frc_axil_regbank #(
      .DATA_W(32), .NUM_REGS(8), .ADDR_W(12), .RO_MASK(8'h80),
      .RESET_VAL({32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000100})
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .ctrl_out(ctrl_out), .status_in(status_in),
`ifdef FRC_SHADOW_EN
      .commit_in(commit_in),
`endif
      .wr_pulse(wr_pulse)
   );

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [7:0] p1, output logic [7:0] p2, output bit ok);
      logic aw_done, w_done;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      ok = 1'b0; resp = 2'b11; p1 = '0; p2 = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         aw_done = awvalid && awready;
         w_done = wvalid && wready;
         @(posedge clk); #1;
         if (aw_done) awvalid = 1'b0;
         if (w_done) wvalid = 1'b0;
         if (bvalid) begin ok = 1'b1; resp = bresp; p1 = wr_pulse; end
      end
      @(posedge clk); #1;
      p2 = wr_pulse; bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp, output bit ok);
      logic ar_done;
      araddr = a; arvalid = 1'b1; rready = 1'b1; ok = 1'b0; d = 'x; resp = 2'b11;
      for (int i = 0; i < 20 && !ok; i++) begin
         ar_done = arvalid && arready;
         @(posedge clk); #1;
         if (ar_done) arvalid = 1'b0;
         if (rvalid) begin ok = 1'b1; d = rdata; resp = rresp; end
      end
      @(posedge clk); #1;
      rready = 1'b0; arvalid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b exp=111", {awready, wready, arready}); end
      total++; if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin bad++; $display("FAIL reset_resp got=%b exp=000000", {bvalid, rvalid, bresp, rresp}); end
      total++; if (rdata !== 32'h0 || wr_pulse !== 8'h0) begin bad++; $display("FAIL reset_rdata_pulse rdata=%h pulse=%h exp=0", rdata, wr_pulse); end
      total++; if (ctrl_out[31:0] !== 32'h100 || ctrl_out[191:160] !== 32'hCAFEF00D) begin bad++; $display("FAIL reset_val r0=%h r5=%h exp=100/cafef00d", ctrl_out[31:0], ctrl_out[191:160]); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] d; bit ok;
      for (int i = 0; i < 4; i++) begin
         axi_write(12'(4*i), 32'(i+1), 4'hF, resp, p1, p2, ok);
         total++; if (!ok || resp !== 2'b00) begin bad++; $display("FAIL basic_bresp idx=%0d ok=%0d got=%b exp=00", i, ok, resp); end
         total++; if (p1 !== 8'(1 << i) || p2 !== 8'h0) begin bad++; $display("FAIL basic_pulse idx=%0d got=%h,%h exp=%h,00", i, p1, p2, 8'(1 << i)); end
`ifndef FRC_SHADOW_EN
         total++; if (ctrl_out[32*i +: 32] !== 32'(i+1)) begin bad++; $display("FAIL basic_ctrl idx=%0d got=%h exp=%h", i, ctrl_out[32*i +: 32], i+1); end
`endif
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(12'(4*i), d, resp, ok);
         total++; if (!ok || resp !== 2'b00 || d !== 32'(i+1)) begin bad++; $display("FAIL basic_read idx=%0d ok=%0d got=%h/%b exp=%h/00", i, ok, d, resp, i+1); end
      end
      axi_read(12'h6, d, resp, ok);
      total++; if (!ok || d !== 32'h2) begin bad++; $display("FAIL unaligned_read got=%h exp=00000002", d); end
   endtask

   task automatic test_strobe;
      logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] d; bit ok;
      axi_write(12'h8, 32'hAABBCCDD, 4'hF, resp, p1, p2, ok);
      axi_write(12'h8, 32'h11223344, 4'b0101, resp, p1, p2, ok);
      axi_read(12'h8, d, resp, ok);
      total++; if (!ok || d !== 32'hAA22CC44) begin bad++; $display("FAIL strobe_read got=%h exp=aa22cc44", d); end
   endtask

   task automatic test_read_only;
      logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] d; bit ok;
      axi_write(12'h1C, 32'h0, 4'hF, resp, p1, p2, ok);
      total++; if (!ok || resp !== 2'b00) begin bad++; $display("FAIL ro_bresp got=%b exp=00", resp); end
      total++; if (p1 !== 8'h80) begin bad++; $display("FAIL ro_pulse got=%h exp=80", p1); end
      axi_read(12'h1C, d, resp, ok);
      total++; if (!ok || resp !== 2'b00 || d !== 32'hDEADBEEF) begin bad++; $display("FAIL ro_read got=%h/%b exp=deadbeef/00", d, resp); end
   endtask

   task automatic test_out_of_range;
      logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] d; bit ok;
      axi_write(12'h20, 32'hFFFFFFFF, 4'hF, resp, p1, p2, ok);
      total++; if (!ok || resp !== 2'b10) begin bad++; $display("FAIL oor_bresp got=%b exp=10", resp); end
      total++; if (p1 !== 8'h0) begin bad++; $display("FAIL oor_pulse got=%h exp=00", p1); end
      axi_read(12'h20, d, resp, ok);
      total++; if (!ok || resp !== 2'b10 || d !== 32'h0) begin bad++; $display("FAIL oor_read got=%h/%b exp=00000000/10", d, resp); end
      axi_read(12'h0, d, resp, ok);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL oor_r0_kept got=%h exp=00000001", d); end
      axi_read(12'h8, d, resp, ok);
      total++; if (d !== 32'hAA22CC44) begin bad++; $display("FAIL oor_r2_kept got=%h exp=aa22cc44", d); end
   endtask

   task automatic test_w_first;
      logic [1:0] resp; logic [31:0] d; bit ok;
      int pulses = 0;
      bit stable = 1'b1;
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      @(posedge clk); #1;
      total++; if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin bad++; $display("FAIL wfirst_hold wready=%b bvalid=%b awready=%b exp=0,0,1", wready, bvalid, awready); end
      wvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      awaddr = 12'h10; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      total++; if (bvalid !== 1'b1 || wr_pulse !== 8'h10) begin bad++; $display("FAIL wfirst_commit bvalid=%b pulse=%h exp=1,10", bvalid, wr_pulse); end
      for (int k = 0; k < 5; k++) begin
         if (bvalid !== 1'b1 || bresp !== 2'b00) stable = 1'b0;
         pulses += $countones(wr_pulse);
         if (k < 4) begin @(posedge clk); #1; end
      end
      total++; if (!stable || pulses != 1) begin bad++; $display("FAIL wfirst_bhold stable=%0d pulses=%0d exp=1,1", stable, pulses); end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      total++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin bad++; $display("FAIL wfirst_bdone bvalid=%b awready=%b wready=%b exp=0,1,1", bvalid, awready, wready); end
      axi_read(12'h10, d, resp, ok);
      total++; if (!ok || d !== 32'h77) begin bad++; $display("FAIL wfirst_read got=%h exp=00000077", d); end
   endtask

   task automatic test_same_edge;
      logic [1:0] resp; logic [31:0] d; bit ok;
      awaddr = 12'hC; araddr = 12'hC; wdata = 32'h99; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      total++; if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h4) begin bad++; $display("FAIL same_edge_old bvalid=%b rvalid=%b rdata=%h exp=1,1,00000004", bvalid, rvalid, rdata); end
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0;
      axi_read(12'hC, d, resp, ok);
      total++; if (!ok || d !== 32'h99) begin bad++; $display("FAIL same_edge_new got=%h exp=00000099", d); end
   endtask

`ifdef FRC_SHADOW_EN
   task automatic test_shadow;
      logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] d; bit ok;
      axi_write(12'h0, 32'h55, 4'hF, resp, p1, p2, ok);
      axi_read(12'h0, d, resp, ok);
      total++; if (!ok || d !== 32'h55) begin bad++; $display("FAIL shadow_read got=%h exp=00000055", d); end
      total++; if (ctrl_out[31:0] !== 32'h100) begin bad++; $display("FAIL shadow_precommit got=%h exp=00000100", ctrl_out[31:0]); end
      commit_in = 1'b1;
      @(posedge clk); #1;
      commit_in = 1'b0;
      total++; if (ctrl_out[31:0] !== 32'h55) begin bad++; $display("FAIL shadow_commit got=%h exp=00000055", ctrl_out[31:0]); end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_strobe();
      test_read_only();
      test_out_of_range();
      test_w_first();
      test_same_edge();
`ifdef FRC_SHADOW_EN
      test_shadow();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
